// File: rtl/adc_capture_buffer.sv
// Multi-channel ADC snapshot capture engine.
// Records every valid sample word into a circular buffer, stops a programmable
// number of samples after a software or level trigger, then replays the window
// oldest-first as a channel-serialised valid/ready stream.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing captured, waiting for ARM
// FILL   | collecting the pre-trigger history, triggers ignored
// WAIT   | history full, buffer keeps rolling, looking for a trigger
// POST   | trigger seen, collecting the remaining post-trigger samples
// READ   | streaming the captured window out
// DONE   | window delivered, buffer frozen until ARM or ABORT
module adc_capture_buffer #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_CH*DATA_W-1:0] ADC_DATA,
    input  logic                     ADC_VALID,
    input  logic                     ARM,
    input  logic                     ABORT,
    input  logic                     SW_TRIG,
    input  logic                     TRIG_EN,
    input  logic [CH_W-1:0]          TRIG_CH,
    input  logic [DATA_W-1:0]        TRIG_LVL,
    input  logic [ADDR_W-1:0]        PRE_CNT,
    input  logic [NUM_CH-1:0]        CH_EN,
    output logic [DATA_W-1:0]        RD_DATA,
    output logic [CH_W-1:0]          RD_CH,
    output logic                     RD_VALID,
    input  logic                     RD_READY,
    output logic                     RD_LAST,
    output logic                     BUSY,
    output logic                     DONE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_READ = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                   state;
    logic [NUM_CH*DATA_W-1:0] mem [DEPTH];

    // Capture configuration, frozen at ARM.
    logic [ADDR_W-1:0]        pre_q;
    logic [NUM_CH-1:0]        en_q;
    logic                     trig_en_q;
    logic [CH_W-1:0]          trig_ch_q;
    logic [DATA_W-1:0]        trig_lvl_q;

    logic [ADDR_W-1:0]        wr_ptr;
    logic [ADDR_W-1:0]        fill_rem;
    logic [ADDR_W-1:0]        post_rem;
    logic [ADDR_W-1:0]        trig_addr;
    logic [ADDR_W-1:0]        rd_idx;
    logic [NUM_CH*DATA_W-1:0] prev_word;
    logic                     have_prev;

    logic                     cap_we;
    logic [DATA_W-1:0]        prev_lvl;
    logic [DATA_W-1:0]        cur_lvl;
    logic                     trig_hit;
    logic [ADDR_W-1:0]        rd_start;
    logic [CH_W-1:0]          first_c;
    logic                     first_last;
    logic                     nxt_wrap;
    logic [CH_W-1:0]          nxt_ch;
    logic [ADDR_W-1:0]        nxt_idx;
    logic                     nxt_last;

    function automatic logic [DATA_W-1:0] ch_sel(input logic [NUM_CH*DATA_W-1:0] w,
                                                 input logic [CH_W-1:0] c);
        ch_sel = w[int'(c)*DATA_W +: DATA_W];
    endfunction

    function automatic logic [CH_W-1:0] first_en(input logic [NUM_CH-1:0] m);
        first_en = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (m[k]) first_en = CH_W'(k);
    endfunction

    function automatic logic has_after(input logic [NUM_CH-1:0] m, input logic [CH_W-1:0] c);
        has_after = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (k > int'(c) && m[k]) has_after = 1'b1;
    endfunction

    function automatic logic [CH_W-1:0] next_en(input logic [NUM_CH-1:0] m,
                                                input logic [CH_W-1:0] c);
        next_en = c;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (k > int'(c) && m[k]) next_en = CH_W'(k);
    endfunction

    // Write strobe, trigger detection and next readout beat position.
    always_comb begin
        cap_we     = ADC_VALID && !ABORT &&
                     (state == S_FILL || state == S_WAIT || state == S_POST);
        prev_lvl   = ch_sel(prev_word, trig_ch_q);
        cur_lvl    = ch_sel(ADC_DATA, trig_ch_q);
        trig_hit   = SW_TRIG ||
                     (trig_en_q && have_prev && (prev_lvl < trig_lvl_q) && (cur_lvl >= trig_lvl_q));
        rd_start   = trig_addr - pre_q;
        first_c    = first_en(en_q);
        first_last = (ADDR_W'(DEPTH - 1) == '0) && !has_after(en_q, first_c);
        nxt_wrap   = !has_after(en_q, RD_CH);
        nxt_ch     = nxt_wrap ? first_c : next_en(en_q, RD_CH);
        nxt_idx    = nxt_wrap ? rd_idx + ADDR_W'(1) : rd_idx;
        nxt_last   = (nxt_idx == ADDR_W'(DEPTH - 1)) && !has_after(en_q, nxt_ch);
    end

    // Sample buffer; contents are don't-care until written, so no reset.
    always_ff @(posedge CLK) begin
        if (cap_we)
            mem[wr_ptr] <= ADC_DATA;
    end

    // Capture/readout sequencer with registered stream and status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            pre_q      <= '0;
            en_q       <= '0;
            trig_en_q  <= 1'b0;
            trig_ch_q  <= '0;
            trig_lvl_q <= '0;
            wr_ptr     <= '0;
            fill_rem   <= '0;
            post_rem   <= '0;
            trig_addr  <= '0;
            rd_idx     <= '0;
            prev_word  <= '0;
            have_prev  <= 1'b0;
            RD_DATA    <= '0;
            RD_CH      <= '0;
            RD_VALID   <= 1'b0;
            RD_LAST    <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
        end else if (ABORT) begin
            state    <= S_IDLE;
            RD_VALID <= 1'b0;
            RD_LAST  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (ARM) begin
                        // PRE_CNT is ADDR_W wide, so it can never exceed DEPTH-1.
                        pre_q      <= PRE_CNT;
                        en_q       <= (CH_EN == '0) ? NUM_CH'(1) : CH_EN;
                        trig_en_q  <= TRIG_EN;
                        trig_ch_q  <= TRIG_CH;
                        trig_lvl_q <= TRIG_LVL;
                        wr_ptr     <= '0;
                        fill_rem   <= PRE_CNT;
                        have_prev  <= 1'b0;
                        state      <= (PRE_CNT == '0) ? S_WAIT : S_FILL;
                        BUSY       <= 1'b1;
                        DONE       <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (ADC_VALID) begin
                        fill_rem <= fill_rem - ADDR_W'(1);
                        if (fill_rem == ADDR_W'(1))
                            state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ADC_VALID && trig_hit) begin
                        // The trigger sample itself is post-sample 1.
                        trig_addr <= wr_ptr;
                        post_rem  <= ADDR_W'(DEPTH - 1) - pre_q;
                        state     <= (pre_q == ADDR_W'(DEPTH - 1)) ? S_READ : S_POST;
                    end
                end
                S_POST: begin
                    if (ADC_VALID) begin
                        post_rem <= post_rem - ADDR_W'(1);
                        if (post_rem == ADDR_W'(1))
                            state <= S_READ;
                    end
                end
                S_READ: begin
                    if (!RD_VALID) begin
                        rd_idx   <= '0;
                        RD_CH    <= first_c;
                        RD_DATA  <= ch_sel(mem[rd_start], first_c);
                        RD_LAST  <= first_last;
                        RD_VALID <= 1'b1;
                    end else if (RD_READY) begin
                        if (RD_LAST) begin
                            RD_VALID <= 1'b0;
                            RD_LAST  <= 1'b0;
                            state    <= S_DONE;
                            BUSY     <= 1'b0;
                            DONE     <= 1'b1;
                        end else begin
                            rd_idx  <= nxt_idx;
                            RD_CH   <= nxt_ch;
                            RD_DATA <= ch_sel(mem[rd_start + nxt_idx], nxt_ch);
                            RD_LAST <= nxt_last;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase

            if (cap_we) begin
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                prev_word <= ADC_DATA;
                have_prev <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer (4 channels, 12-bit, depth 16).
// Each capture's expected beat stream is derived from the list of valid
// samples driven: locate the trigger sample, cut the window around it,
// serialise the enabled channels. A monitor checks every accepted beat and
// stall stability against that stream.
module tb_adc_capture_buffer;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CH_W   = 2;

    logic                     CLK = 1'b0;
    logic                     RST = 1'b1;
    logic [NUM_CH*DATA_W-1:0] ADC_DATA = '0;
    logic                     ADC_VALID = 1'b0;
    logic                     ARM = 1'b0;
    logic                     ABORT = 1'b0;
    logic                     SW_TRIG = 1'b0;
    logic                     TRIG_EN = 1'b0;
    logic [CH_W-1:0]          TRIG_CH = '0;
    logic [DATA_W-1:0]        TRIG_LVL = '0;
    logic [ADDR_W-1:0]        PRE_CNT = '0;
    logic [NUM_CH-1:0]        CH_EN = '0;
    logic [DATA_W-1:0]        RD_DATA;
    logic [CH_W-1:0]          RD_CH;
    logic                     RD_VALID;
    logic                     RD_READY = 1'b0;
    logic                     RD_LAST;
    logic                     BUSY;
    logic                     DONE;

    always #5 CLK = ~CLK;

    adc_capture_buffer #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID),
        .ARM(ARM), .ABORT(ABORT), .SW_TRIG(SW_TRIG), .TRIG_EN(TRIG_EN),
        .TRIG_CH(TRIG_CH), .TRIG_LVL(TRIG_LVL), .PRE_CNT(PRE_CNT), .CH_EN(CH_EN),
        .RD_DATA(RD_DATA), .RD_CH(RD_CH), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .RD_LAST(RD_LAST), .BUSY(BUSY), .DONE(DONE)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CH_W-1:0]   c;
        logic              l;
    } beat_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    int    rx_d[$];
    int    rx_c[$];
    int    rx_l[$];
    bit    rdy_rand = 1'b0;
    bit    gap_sw   = 1'b0;
    int    base     = 0;
    int    stim_gap[64];
    bit    stim_sw[64];

    function automatic logic [DATA_W-1:0] samp(int n, int k);
        return DATA_W'((base + n + 40 * k) & 'hFFF);
    endfunction

    function automatic logic [NUM_CH*DATA_W-1:0] word(int n);
        logic [NUM_CH*DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_CH; k++) w[k*DATA_W +: DATA_W] = samp(n, k);
        return w;
    endfunction

    task automatic chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < 64; i++) begin
            stim_gap[i] = 0;
            stim_sw[i]  = 1'b0;
        end
        gap_sw = 1'b0;
    endtask

    // Window model: trigger is the first valid sample at index >= pre that has
    // SW_TRIG or an upward crossing versus the previous valid sample.
    task automatic build_expect(int pre, logic [3:0] ch_en, bit ten, int tch, int lvl, int n);
        int         trig;
        bit         lv;
        logic [3:0] mask;
        beat_t      b;
        trig = -1;
        for (int i = pre; i < n; i++) begin
            lv = ten && (i >= 1) && (int'(samp(i - 1, tch)) < lvl) && (int'(samp(i, tch)) >= lvl);
            if (trig < 0 && (stim_sw[i] || lv)) trig = i;
        end
        mask = (ch_en == 4'b0000) ? 4'b0001 : ch_en;
        exp_q.delete();
        if (trig < 0 || trig + DEPTH - pre > n) begin
            n_checks++;
            n_fail++;
            $display("FAIL model_window trig=%0d pre=%0d samples=%0d", trig, pre, n);
        end else begin
            for (int j = 0; j < DEPTH; j++)
                for (int c = 0; c < NUM_CH; c++)
                    if (mask[c]) begin
                        b.d = samp(trig - pre + j, c);
                        b.c = CH_W'(c);
                        b.l = (j == DEPTH - 1) && ((mask >> (c + 1)) == 4'b0000);
                        exp_q.push_back(b);
                    end
        end
    endtask

    task automatic run_capture(int pre, logic [3:0] ch_en, bit ten, int tch, int lvl, int n,
                               bit build, int arm_again_at, int abort_after);
        int k;
        if (build) build_expect(pre, ch_en, ten, tch, lvl, n);
        else exp_q.delete();
        rx_d.delete(); rx_c.delete(); rx_l.delete();
        @(posedge CLK); #1;
        ARM = 1'b1; PRE_CNT = ADDR_W'(pre); CH_EN = ch_en; TRIG_EN = ten;
        TRIG_CH = CH_W'(tch); TRIG_LVL = DATA_W'(lvl);
        @(posedge CLK); #1;
        // Scramble live config to prove it was latched at ARM.
        ARM = 1'b0; PRE_CNT = ~ADDR_W'(pre); CH_EN = ~ch_en; TRIG_EN = ~ten;
        TRIG_LVL = ~DATA_W'(lvl);
        chk("busy_after_arm", int'(BUSY), 1);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < stim_gap[i]; g++) begin
                ADC_VALID = 1'b0; ADC_DATA = '1; SW_TRIG = gap_sw;
                @(posedge CLK); #1;
            end
            ADC_VALID = 1'b1; ADC_DATA = word(i); SW_TRIG = stim_sw[i];
            if (i == arm_again_at) begin
                ARM = 1'b1; PRE_CNT = ADDR_W'(9);
            end
            @(posedge CLK); #1;
            ARM = 1'b0;
            if (i == abort_after) begin
                ADC_VALID = 1'b0; SW_TRIG = 1'b0; ABORT = 1'b1;
                @(posedge CLK); #1;
                ABORT = 1'b0;
                @(negedge CLK);
                chk("abort_busy", int'(BUSY), 0);
                chk("abort_done", int'(DONE), 0);
                chk("abort_rd_valid", int'(RD_VALID), 0);
                repeat (40) @(negedge CLK);
                chk("abort_stays_idle", int'(BUSY | DONE | RD_VALID), 0);
                return;
            end
        end
        ADC_VALID = 1'b0; SW_TRIG = 1'b0;
        k = 0;
        while (!DONE && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        chk("done_reached", int'(DONE), 1);
        chk("busy_in_done", int'(BUSY), 0);
        chk("rd_valid_in_done", int'(RD_VALID), 0);
        chk("beats_outstanding", exp_q.size(), 0);
    endtask

    // Ready source: constant or random per cycle.
    initial begin
        forever begin
            @(posedge CLK); #1;
            RD_READY = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Stream monitor.
    initial begin
        bit    pv, pr, pl;
        int    pd, pc;
        beat_t e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 0; pc = 0;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (pv && !pr) begin
                    chk("stall_valid", int'(RD_VALID), 1);
                    chk("stall_data", int'(RD_DATA), pd);
                    chk("stall_ch", int'(RD_CH), pc);
                    chk("stall_last", int'(RD_LAST), int'(pl));
                end
                if (RD_VALID && RD_READY) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat data=%0d ch=%0d required=none", RD_DATA, RD_CH);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", int'(RD_DATA), int'(e.d));
                        chk("beat_ch", int'(RD_CH), int'(e.c));
                        chk("beat_last", int'(RD_LAST), int'(e.l));
                    end
                    rx_d.push_back(int'(RD_DATA));
                    rx_c.push_back(int'(RD_CH));
                    rx_l.push_back(int'(RD_LAST));
                end
            end
            pv = RD_VALID; pr = RD_READY; pd = int'(RD_DATA); pc = int'(RD_CH); pl = RD_LAST;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        chk("rst_rd_valid", int'(RD_VALID), 0);
        chk("rst_rd_last", int'(RD_LAST), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_rd_data", int'(RD_DATA), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("idle_busy", int'(BUSY), 0);

        // 1: software trigger on sample 10, all channels, always ready.
        clear_stim(); base = 0; stim_sw[10] = 1'b1;
        run_capture(4, 4'b1111, 1'b0, 0, 0, 24, 1'b1, -1, -1);
        chk("t1_beats", rx_d.size(), 64);
        chk("t1_first_ch0", rx_d[0], 6);
        chk("t1_first_ch1", rx_d[1], 46);
        chk("t1_last_ch0", rx_d[60], 21);
        chk("t1_last_flag", rx_l[63], 1);
        chk("t1_not_last", rx_l[62], 0);

        // 2: level trigger on ch2 crossing 100 (98, 99, 100).
        clear_stim(); base = 10;
        run_capture(4, 4'b1111, 1'b1, 2, 100, 24, 1'b1, -1, -1);
        chk("t2_trig_sample", rx_d[18], 100);
        chk("t2_trig_ch", rx_c[18], 2);
        chk("t2_first_ch2", rx_d[2], 96);

        // 3: sparse channels with random backpressure.
        clear_stim(); base = 0; stim_sw[8] = 1'b1; rdy_rand = 1'b1;
        run_capture(4, 4'b1010, 1'b0, 0, 0, 24, 1'b1, -1, -1);
        rdy_rand = 1'b0;
        chk("t3_beats", rx_d.size(), 32);
        for (int i = 0; i < rx_c.size(); i++) chk("t3_ch_alt", rx_c[i], (i % 2 == 1) ? 3 : 1);
        chk("t3_first", rx_d[0], 44);
        chk("t3_final", rx_d[31], 139);

        // 4a: PRE_CNT=0, CH_EN=0 means ch0 only.
        clear_stim(); base = 0; stim_sw[5] = 1'b1;
        run_capture(0, 4'b0000, 1'b0, 0, 0, 24, 1'b1, -1, -1);
        chk("t4a_beats", rx_d.size(), 16);
        chk("t4a_first", rx_d[0], 5);
        chk("t4a_final", rx_d[15], 20);

        // 4b: PRE_CNT=15, window ends at the trigger; FILL trigger ignored.
        clear_stim(); base = 0; stim_sw[3] = 1'b1; stim_sw[20] = 1'b1;
        run_capture(15, 4'b0001, 1'b0, 0, 0, 24, 1'b1, -1, -1);
        chk("t4b_beats", rx_d.size(), 16);
        chk("t4b_first", rx_d[0], 5);
        chk("t4b_final", rx_d[15], 20);
        chk("t4b_last_flag", rx_l[15], 1);

        // 5: abort mid-POST, then a clean capture.
        clear_stim(); base = 0; stim_sw[6] = 1'b1;
        run_capture(4, 4'b1111, 1'b0, 0, 0, 24, 1'b0, -1, 9);
        clear_stim(); base = 5; stim_sw[3] = 1'b1;
        run_capture(2, 4'b0011, 1'b0, 0, 0, 20, 1'b1, -1, -1);
        chk("t5_beats", rx_d.size(), 32);
        chk("t5_first", rx_d[0], 6);

        // 6: re-ARM while busy, SW_TRIG in FILL, valid gaps with SW_TRIG high.
        clear_stim(); base = 0; stim_sw[1] = 1'b1; stim_sw[9] = 1'b1;
        stim_gap[3] = 2; stim_gap[7] = 3; stim_gap[11] = 2; gap_sw = 1'b1;
        run_capture(4, 4'b0101, 1'b0, 0, 0, 23, 1'b1, 6, -1);
        chk("t6_beats", rx_d.size(), 32);
        chk("t6_first_ch0", rx_d[0], 5);
        chk("t6_first_ch2", rx_d[1], 85);
        chk("t6_final_ch0", rx_d[30], 20);

        repeat (4) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
